// File: rtl/axis_tb_pkg.sv
// Shared types and helpers for the AXI4-Stream checker slice.
// Holds the FSM state enum, default backpressure masks and a saturating increment.
package axis_tb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  localparam logic [15:0] READY_ALWAYS = 16'hFFFF;
  localparam logic [15:0] READY_HALF   = 16'h5555;
  localparam logic [15:0] READY_SPARSE = 16'h0001;

  localparam int unsigned SAT_MAX_WIDTH = 64;

  // Increment, holding at all-ones for the given width (width <= SAT_MAX_WIDTH).
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(input logic [SAT_MAX_WIDTH-1:0] value,
                                                       input int unsigned width);
    logic [SAT_MAX_WIDTH-1:0] max_val;
    max_val = (width >= SAT_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous active-low reset.
module sat_counter
  import axis_tb_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(count), CNT_WIDTH));
    end
  end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink: patterned backpressure, incrementing-sequence data check,
// stability monitoring, saturating counters and first-error capture.
module axis_stream_checker
  import axis_tb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter logic [15:0]           READY_PATTERN = READY_ALWAYS,
  parameter logic [DATA_WIDTH-1:0] START_VALUE   = '0,
  parameter int unsigned           CNT_WIDTH     = 32,
  parameter bit                    HALT_ON_ERR   = 1'b0
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,
  input  logic                  sink_en,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  proto_err_count,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic                  err_flag
);

  state_t                state_q;
  logic [15:0]           pat_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  err_flag_q;
  logic [DATA_WIDTH-1:0] first_err_data_q;
  logic [DATA_WIDTH-1:0] first_err_exp_q;

  logic handshake;
  logic data_ok;
  logic mismatch;
  logic proto_viol;

  // Ready comes only from registered state, never from tvalid.
  assign s00_axis_tready = (state_q == RUN) && pat_q[0];

  assign handshake  = s00_axis_tvalid && s00_axis_tready;
  assign data_ok    = (s00_axis_tdata == exp_q);
  assign mismatch   = handshake && !data_ok;
  assign proto_viol = stall_q && (!s00_axis_tvalid || (s00_axis_tdata != hold_q));

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q          <= IDLE;
      pat_q            <= READY_PATTERN;
      exp_q            <= START_VALUE;
      err_flag_q       <= 1'b0;
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
    end else if (clear) begin
      state_q          <= IDLE;
      pat_q            <= READY_PATTERN;
      exp_q            <= START_VALUE;
      err_flag_q       <= 1'b0;
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sink_en) state_q <= RUN;
        end
        RUN: begin
          pat_q <= {pat_q[0], pat_q[15:1]};
          if (mismatch && HALT_ON_ERR) state_q <= HALT;
          else if (!sink_en)           state_q <= IDLE;
        end
        HALT: state_q <= HALT;
        default: state_q <= IDLE;
      endcase

      // A bad beat resynchronises the sequence so one glitch costs one error.
      if (handshake) begin
        exp_q <= data_ok ? exp_q + DATA_WIDTH'(1) : s00_axis_tdata + DATA_WIDTH'(1);
      end

      if (mismatch && !err_flag_q) begin
        err_flag_q       <= 1'b1;
        first_err_data_q <= s00_axis_tdata;
        first_err_exp_q  <= exp_q;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      stall_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      stall_q <= s00_axis_tvalid && !s00_axis_tready;
      hold_q  <= s00_axis_tdata;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_beat_cnt (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .clear (clear),
    .inc   (handshake),
    .count (beat_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .clear (clear),
    .inc   (handshake && s00_axis_tlast),
    .count (pkt_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .clear (clear),
    .inc   (mismatch),
    .count (err_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_proto_cnt (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .clear (clear),
    .inc   (proto_viol),
    .count (proto_err_count)
  );

  assign first_err_data = first_err_data_q;
  assign first_err_exp  = first_err_exp_q;
  assign err_flag       = err_flag_q;

endmodule

// File: doc/axis_stream_checker.md
# axis_stream_checker

AXI4-Stream slave-side checker that terminates the stream driven by the data generator and by the ChaCha core's output port in simulation and on-board bring-up. It drives `s00_axis_tready` with a configurable backpressure pattern, checks every accepted beat against an incrementing expected sequence, and monitors AXI-Stream stability rules. Results are exposed as saturating counters and sticky flags for the bench or an AXI-Lite status wrapper.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `tdata` and of the expected-value register.
- `READY_PATTERN`, 16'hFFFF: rotating backpressure mask; bit 0 is applied first.
- `START_VALUE`, 0: first expected data value after reset or `clear`.
- `CNT_WIDTH`, 32: width of all counters.
- `HALT_ON_ERR`, 0: 1 = enter HALT on first data mismatch.

Ports:
- `s00_axis_aclk` in 1: the block's single clock.
- `s00_axis_aresetn` in 1: asynchronous, active-low reset.
- `s00_axis_tdata` in DATA_WIDTH: stream data.
- `s00_axis_tvalid` in 1: stream valid.
- `s00_axis_tlast` in 1: packet end marker.
- `s00_axis_tready` out 1: sink ready.
- `sink_en` in 1: 1 = accept data; 0 = tready held low.
- `clear` in 1: synchronous; zeroes counters/flags, reloads expected value, leaves HALT.
- `beat_count` out CNT_WIDTH: accepted beats.
- `pkt_count` out CNT_WIDTH: accepted beats with tlast=1.
- `err_count` out CNT_WIDTH: data mismatches.
- `proto_err_count` out CNT_WIDTH: stability violations.
- `first_err_data`, `first_err_exp` out DATA_WIDTH: received/expected values of first mismatch.
- `err_flag` out 1: sticky, set on first mismatch.

## Operation
- States: IDLE (tready 0), RUN (tready = `pat_q[0]`), HALT (tready 0). IDLE->RUN when `sink_en`=1; RUN->IDLE when `sink_en`=0; RUN->HALT on mismatch if `HALT_ON_ERR`=1; HALT->IDLE only on `clear`. `clear` has priority over all other transitions.
- `pat_q` loads `READY_PATTERN` at reset/`clear`, rotates right by 1 every cycle in RUN only.
- Handshake = tvalid & tready. On handshake: `beat_count`+1; `pkt_count`+1 if tlast; compare tdata to `exp_q`.
- Match: `exp_q` <= `exp_q`+1 (mod 2^DATA_WIDTH, wraps silently).
- Mismatch: `err_count`+1; `exp_q` <= tdata+1 (resync, one error per glitch); if `err_flag`=0, capture `first_err_data`/`first_err_exp` and set `err_flag`.
- Stability monitor: register `stall_q` = tvalid & !tready and `hold_q` = tdata. If `stall_q`=1 and this cycle tvalid=0 or tdata != `hold_q`, `proto_err_count`+1. Monitor active in all states.
- All counters saturate at all-ones; no wrap.
- Reset values: tready 0, all counters 0, `err_flag` 0, `first_err_*` 0, `exp_q` = START_VALUE, state IDLE, `stall_q` 0.

## Timing
- tready is a function of registered state and `pat_q` only; never combinationally depends on tvalid.
- First possible tready high: cycle after `sink_en` sampled 1 (IDLE->RUN edge).
- Counter/flag outputs update on the clock edge that completes the handshake (visible one cycle after the handshake cycle).
- Mismatch with `HALT_ON_ERR`=1: tready low from the next cycle; the mismatched beat itself is counted.
- `clear` coincident with a handshake: clear wins, the beat is not counted, `exp_q` = START_VALUE.
- Async reset mid-transfer: tready drops immediately; a pending stall is forgotten (no proto error after release).

## Structure
- Shared package `axis_tb_pkg`: state enum (IDLE/RUN/HALT), saturating-increment function, default pattern constants.
- One natural sub-module: `sat_counter` (CNT_WIDTH, inc, clear), instantiated four times.

## Test plan
- Incrementing 0..19 from generator, READY_PATTERN=16'hFFFF -> beat_count=20, err_count=0, tready high continuously in RUN.
- READY_PATTERN=16'h5555, 10 beats -> tready alternates 1/0, beat_count=10, proto_err_count=0.
- Inject 0,1,2,7,8 -> err_count=1, first_err_data=7, first_err_exp=3, no further errors.
- Drop tvalid while tready=0 (pattern 16'h0001 after valid asserted), and separately change tdata under stall -> proto_err_count=2.
- HALT_ON_ERR=1, mismatch at beat 5 -> beat_count=5 (incl. bad beat), tready 0 until `clear`, then counters 0, state IDLE.
- Assert aresetn low mid-packet with tvalid=1, tready=0 -> all outputs at reset values, no proto error after release; exp_q wrap at DATA_WIDTH=8: 255 then 0 -> no error.
